// File: rtl/peri_bridge_axl_if.sv
`default_nettype none
// ============================================================================
// Module   : peri_bridge_axl_if
// Brief    : Core-request and peripheral-channel signal bundle for peri_bridge_axl.
// Revision : 1.0
// ============================================================================
interface peri_bridge_axl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  START;
    logic [ADDR_W-1:0]     ADDRESS;
    logic                  WRITE;
    logic [DATA_W-1:0]     DATA_IN;
    logic [DATA_W/8-1:0]   WSTRB;
    logic [DATA_W-1:0]     DATA_OUT;
    logic                  DONE;
    logic                  ERROR;
    logic                  BUSY;
    logic                  CACHE_READY_DAT;
    logic [ADDR_W-1:0]     RD_ADDR_TO_PERI;
    logic                  RD_ADDR_TO_PERI_VALID;
    logic                  RD_ADDR_TO_PERI_READY;
    logic [ADDR_W-1:0]     WR_ADDR_TO_PERI;
    logic [DATA_W-1:0]     DATA_TO_PERI;
    logic [DATA_W/8-1:0]   WSTRB_OUT;
    logic                  WR_TO_PERI_VALID;
    logic                  WR_TO_PERI_READY;
    logic [DATA_W-1:0]     DATA_FROM_PERI;
    logic                  DATA_FROM_PERI_VALID;
    logic                  DATA_FROM_PERI_READY;
    logic                  TRANSACTION_COMPLETE_PERI;

    // Bridge view: accepts core requests, masters the peripheral channel.
    modport master (
        input  START, ADDRESS, WRITE, DATA_IN, WSTRB, CACHE_READY_DAT,
               RD_ADDR_TO_PERI_READY, WR_TO_PERI_READY, DATA_FROM_PERI,
               DATA_FROM_PERI_VALID, TRANSACTION_COMPLETE_PERI,
        output DATA_OUT, DONE, ERROR, BUSY, RD_ADDR_TO_PERI, RD_ADDR_TO_PERI_VALID,
               WR_ADDR_TO_PERI, DATA_TO_PERI, WSTRB_OUT, WR_TO_PERI_VALID,
               DATA_FROM_PERI_READY
    );

    modport slave (
        output START, ADDRESS, WRITE, DATA_IN, WSTRB, CACHE_READY_DAT,
               RD_ADDR_TO_PERI_READY, WR_TO_PERI_READY, DATA_FROM_PERI,
               DATA_FROM_PERI_VALID, TRANSACTION_COMPLETE_PERI,
        input  DATA_OUT, DONE, ERROR, BUSY, RD_ADDR_TO_PERI, RD_ADDR_TO_PERI_VALID,
               WR_ADDR_TO_PERI, DATA_TO_PERI, WSTRB_OUT, WR_TO_PERI_VALID,
               DATA_FROM_PERI_READY
    );
endinterface
`default_nettype wire

// File: rtl/peri_bridge_axl.sv
`default_nettype none
// ============================================================================
// Module   : peri_bridge_axl
// Brief    : Single-beat core request to handshaked peripheral transfer bridge.
//            Define PERI_TIMEOUT_EN for the watchdog with ERROR response.
// Revision : 1.0
// ============================================================================
module peri_bridge_axl #(
    parameter int          ADDR_W         = 32,
    parameter int          DATA_W         = 32,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  wire                CLK,
    input  wire                RSTN,
    peri_bridge_axl_if.master  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [DATA_W-1:0] c_err_data = DATA_W'(ERR_DATA);

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]     dout_q, dout_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  wr_vld_q, wr_vld_d;
    logic                  rd_vld_q, rd_vld_d;
    logic                  rd_rdy_q, rd_rdy_d;
    logic                  a_ok_q, a_ok_d;
    logic                  d_ok_q, d_ok_d;
    logic                  c_ok_q, c_ok_d;
    logic                  w_xfer;
    logic                  w_tmo;

    assign w_xfer = (state_q == S_WR) || (state_q == S_RD);

`ifdef PERI_TIMEOUT_EN
    localparam int                  c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]  c_tmo_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] cnt_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt_q <= '0;
        end else if (state_q == S_IDLE) begin
            cnt_q <= '0;
        end else if (w_xfer) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign w_tmo = w_xfer && (cnt_q == c_tmo_last);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
    assign w_tmo        = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= S_IDLE;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wr_vld_q  <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_rdy_q  <= 1'b0;
            a_ok_q    <= 1'b0;
            d_ok_q    <= 1'b0;
            c_ok_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wr_vld_q  <= wr_vld_d;
            rd_vld_q  <= rd_vld_d;
            rd_rdy_q  <= rd_rdy_d;
            a_ok_q    <= a_ok_d;
            d_ok_q    <= d_ok_d;
            c_ok_q    <= c_ok_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        dout_d    = dout_q;
        done_d    = done_q;
        err_d     = err_q;
        wr_vld_d  = wr_vld_q;
        rd_vld_d  = rd_vld_q;
        rd_rdy_d  = rd_rdy_q;
        a_ok_d    = a_ok_q;
        d_ok_d    = d_ok_q;
        c_ok_d    = c_ok_q;

        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    rd_addr_d = bus.ADDRESS;
                    wr_addr_d = bus.ADDRESS;
                    wdata_d   = bus.DATA_IN;
                    wstrb_d   = bus.WSTRB;
                    a_ok_d    = 1'b0;
                    d_ok_d    = 1'b0;
                    c_ok_d    = 1'b0;
                    if (bus.WRITE) begin
                        state_d  = S_WR;
                        wr_vld_d = 1'b1;
                    end else begin
                        state_d  = S_RD;
                        rd_vld_d = 1'b1;
                        rd_rdy_d = 1'b1;
                    end
                end
            end
            S_WR: begin
                // Address and data travel together, so one handshake satisfies both.
                if (wr_vld_q && bus.WR_TO_PERI_READY) begin
                    wr_vld_d = 1'b0;
                    a_ok_d   = 1'b1;
                    d_ok_d   = 1'b1;
                end
                if (bus.TRANSACTION_COMPLETE_PERI) c_ok_d = 1'b1;
            end
            S_RD: begin
                if (rd_vld_q && bus.RD_ADDR_TO_PERI_READY) begin
                    rd_vld_d = 1'b0;
                    a_ok_d   = 1'b1;
                end
                if (rd_rdy_q && bus.DATA_FROM_PERI_VALID) begin
                    rd_rdy_d = 1'b0;
                    d_ok_d   = 1'b1;
                    dout_d   = bus.DATA_FROM_PERI;
                end
                if (bus.TRANSACTION_COMPLETE_PERI) c_ok_d = 1'b1;
            end
            S_RESP: begin
                if (bus.CACHE_READY_DAT) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Normal completion outranks a watchdog expiry on the same cycle.
        if (w_xfer && a_ok_d && d_ok_d && c_ok_d) begin
            state_d = S_RESP;
            done_d  = 1'b1;
            err_d   = 1'b0;
        end else if (w_tmo) begin
            state_d  = S_RESP;
            done_d   = 1'b1;
            err_d    = 1'b1;
            wr_vld_d = 1'b0;
            rd_vld_d = 1'b0;
            rd_rdy_d = 1'b0;
            if (state_q == S_RD) dout_d = c_err_data;
        end
    end

    assign bus.DATA_OUT              = dout_q;
    assign bus.DONE                  = done_q;
    assign bus.ERROR                 = err_q;
    assign bus.BUSY                  = (state_q != S_IDLE);
    assign bus.RD_ADDR_TO_PERI       = rd_addr_q;
    assign bus.RD_ADDR_TO_PERI_VALID = rd_vld_q;
    assign bus.WR_ADDR_TO_PERI       = wr_addr_q;
    assign bus.DATA_TO_PERI          = wdata_q;
    assign bus.WSTRB_OUT             = wstrb_q;
    assign bus.WR_TO_PERI_VALID      = wr_vld_q;
    assign bus.DATA_FROM_PERI_READY  = rd_rdy_q;
endmodule
`default_nettype wire

// File: tb/tb_peri_bridge_axl.sv
`default_nettype none
// ============================================================================
// Module   : tb_peri_bridge_axl
// Brief    : Randomised scoreboard bench for peri_bridge_axl.
// Revision : 1.0
// ============================================================================
module tb_peri_bridge_axl;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    peri_bridge_axl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    peri_bridge_axl #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .CLK(clk), .RSTN(rstn), .bus(bus)
    );

    typedef struct { int cyc; logic [31:0] data; logic err; } resp_t;
    typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] s; } wr_t;

    resp_t        resp_q[$];
    wr_t          wr_q[$];
    logic [31:0]  rd_q[$];
    logic [31:0]  model_dout = '0;
    logic         prev_done  = 1'b0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: compares every presented handshake and each new DONE against the queues.
    always @(negedge clk) begin : mon
        resp_t r;
        wr_t   w;
        logic [31:0] a;
        if (!rstn) begin
            prev_done <= 1'b0;
        end else begin
            if (bus.WR_TO_PERI_VALID) begin
                if (wr_q.size() == 0) chk("wr_valid_unexpected", 96'(1), 96'(0));
                else begin
                    w = wr_q[0];
                    chk("wr_payload", 96'({bus.WR_ADDR_TO_PERI, bus.DATA_TO_PERI, bus.WSTRB_OUT}),
                        96'({w.a, w.d, w.s}));
                    if (bus.WR_TO_PERI_READY) void'(wr_q.pop_front());
                end
            end
            if (bus.RD_ADDR_TO_PERI_VALID && bus.RD_ADDR_TO_PERI_READY) begin
                if (rd_q.size() == 0) chk("rd_addr_unexpected", 96'(1), 96'(0));
                else begin
                    a = rd_q.pop_front();
                    chk("rd_addr", 96'(bus.RD_ADDR_TO_PERI), 96'(a));
                end
            end
            if (bus.DONE && !prev_done) begin
                if (resp_q.size() == 0) chk("done_unexpected", 96'(1), 96'(0));
                else begin
                    r = resp_q.pop_front();
                    chk("done_cycle", 96'(cyc), 96'(r.cyc));
                    chk("data_out", 96'(bus.DATA_OUT), 96'(r.data));
                    chk("error", 96'(bus.ERROR), 96'(r.err));
                end
            end
            prev_done <= bus.DONE;
        end
    end

    task automatic clear_peri();
        bus.WR_TO_PERI_READY          = 1'b0;
        bus.RD_ADDR_TO_PERI_READY     = 1'b0;
        bus.DATA_FROM_PERI_VALID      = 1'b0;
        bus.TRANSACTION_COMPLETE_PERI = 1'b0;
    endtask

    task automatic finish_txn(input int ack);
        int n;
        n = 0;
        while (!bus.DONE && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", 96'(bus.DONE), 96'(1));
        for (int i = 0; i < ack; i++) begin
            chk("done_hold", 96'(bus.DONE), 96'(1));
            bus.START   = (i == 0);
            bus.WRITE   = 1'($urandom);
            bus.ADDRESS = $urandom;
            @(posedge clk); #1;
        end
        bus.START           = 1'b0;
        bus.CACHE_READY_DAT = 1'b1;
        @(posedge clk); #1;
        bus.CACHE_READY_DAT = 1'b0;
        chk("done_clear", 96'(bus.DONE), 96'(0));
        chk("busy_idle", 96'(bus.BUSY), 96'(0));
    endtask

    // Peripheral responses are single-cycle pulses k cycles after VALID first rises.
    task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] rdata,
                       input int ra, input int dd, input int cc, input int ack);
        int    mx;
        resp_t r;
        wr_t   w;
        mx = (ra > cc) ? ra : cc;
        if (!wr && dd > mx) mx = dd;
        bus.START   = 1'b1;
        bus.WRITE   = wr;
        bus.ADDRESS = a;
        bus.DATA_IN = d;
        bus.WSTRB   = s;
        if (!wr) model_dout = rdata;
        r.cyc  = cyc + 2 + mx;
        r.data = model_dout;
        r.err  = 1'b0;
        resp_q.push_back(r);
        if (wr) begin
            w.a = a; w.d = d; w.s = s;
            wr_q.push_back(w);
        end else begin
            rd_q.push_back(a);
        end
        @(posedge clk); #1;
        bus.START   = 1'b0;
        bus.ADDRESS = $urandom;
        bus.DATA_IN = $urandom;
        bus.WSTRB   = 4'($urandom);
        for (int k = 0; k <= mx; k++) begin
            bus.WR_TO_PERI_READY          = wr && (k == ra);
            bus.RD_ADDR_TO_PERI_READY     = !wr && (k == ra);
            bus.DATA_FROM_PERI_VALID      = !wr && (k == dd);
            bus.DATA_FROM_PERI            = (!wr && (k == dd)) ? rdata : $urandom;
            bus.TRANSACTION_COMPLETE_PERI = (k == cc);
            @(posedge clk); #1;
        end
        clear_peri();
        finish_txn(ack);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int seen;
        resp_t r;
        bus.START = 1'b0; bus.ADDRESS = '0; bus.WRITE = 1'b0; bus.DATA_IN = '0;
        bus.WSTRB = '0; bus.CACHE_READY_DAT = 1'b0; bus.DATA_FROM_PERI = '0;
        clear_peri();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", 96'({bus.DONE, bus.ERROR, bus.BUSY, bus.RD_ADDR_TO_PERI_VALID,
                              bus.WR_TO_PERI_VALID, bus.DATA_FROM_PERI_READY, bus.WSTRB_OUT,
                              bus.DATA_OUT}), 96'(0));
        chk("reset_addr_data", {bus.RD_ADDR_TO_PERI, bus.WR_ADDR_TO_PERI, bus.DATA_TO_PERI}, 96'(0));
        rstn = 1'b1;
        @(posedge clk); #1;

        txn(1'b1, 32'h4000_0010, 32'h1234_5678, 4'hF, 32'h0, 1, 0, 2, 0);
        txn(1'b0, 32'h4000_0020, 32'h0, 4'h0, 32'hCAFE_0001, 2, 0, 2, 0);
        txn(1'b1, 32'h4000_0030, 32'hA5A5_5A5A, 4'h3, 32'h0, 10, 0, 3, 5);
        txn(1'b0, 32'h4000_0040, 32'h0, 4'h0, 32'h0BAD_F00D, 0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom,
                $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                $urandom_range(0, 3));
        end

        // Reset while a read is outstanding.
        bus.START = 1'b1; bus.WRITE = 1'b0; bus.ADDRESS = 32'h4000_0050;
        @(posedge clk); #1;
        bus.START = 1'b0;
        @(posedge clk); #1;
        chk("rd_valid_before_rst", 96'(bus.RD_ADDR_TO_PERI_VALID), 96'(1));
        rstn = 1'b0;
        #1;
        chk("rst_async_ctrl", 96'({bus.DONE, bus.ERROR, bus.BUSY, bus.RD_ADDR_TO_PERI_VALID,
                                  bus.WR_TO_PERI_VALID, bus.DATA_FROM_PERI_READY, bus.WSTRB_OUT,
                                  bus.DATA_OUT}), 96'(0));
        chk("rst_async_addr_data", {bus.RD_ADDR_TO_PERI, bus.WR_ADDR_TO_PERI, bus.DATA_TO_PERI}, 96'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
        model_dout = '0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            seen += int'(bus.DONE);
            @(posedge clk); #1;
        end
        chk("no_done_after_rst", 96'(seen), 96'(0));

        txn(1'b0, 32'h4000_0060, 32'h0, 4'h0, 32'h1357_9BDF, 3, 5, 1, 1);

`ifdef PERI_TIMEOUT_EN
        bus.START = 1'b1; bus.WRITE = 1'b0; bus.ADDRESS = 32'h4000_0070;
        r.cyc  = cyc + 1 + TMO;
        r.data = 32'hDEAD_BEEF;
        r.err  = 1'b1;
        resp_q.push_back(r);
        rd_q.push_back(32'h4000_0070);
        model_dout = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.START = 1'b0;
        n = 0;
        while (!bus.DONE && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("tmo_handshakes_clear", 96'({bus.RD_ADDR_TO_PERI_VALID, bus.DATA_FROM_PERI_READY,
                                        bus.WR_TO_PERI_VALID}), 96'(0));
        void'(rd_q.pop_front());
        finish_txn(0);
`else
        bus.START = 1'b1; bus.WRITE = 1'b0; bus.ADDRESS = 32'h4000_0070;
        @(posedge clk); #1;
        bus.START = 1'b0;
        seen = 0;
        for (n = 0; n < 100; n++) begin
            seen += int'(bus.DONE);
            @(posedge clk); #1;
        end
        chk("no_done_without_timeout", 96'(seen), 96'(0));
        chk("still_busy", 96'(bus.BUSY), 96'(1));
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        model_dout = '0;
`endif

        txn(1'b1, 32'h4000_0080, 32'hFEED_FACE, 4'h5, 32'h0, 2, 0, 0, 2);

        repeat (3) @(posedge clk);
        #1;
        chk("resp_q_empty", 96'(resp_q.size()), 96'(0));
        chk("wr_q_empty", 96'(wr_q.size()), 96'(0));
        chk("rd_q_empty", 96'(rd_q.size()), 96'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
